sync_ptr_mon: RTL and testbench
===============================

# sync_ptr_mon

Parametrised successor to the two-flop pointer synchronizer. It carries a Gray-coded FIFO pointer from a foreign clock domain into the local domain through a configurable-depth flop chain. It then converts the pointer to binary, reports per-cycle advance (pulse plus modular delta), and runs a sticky overrun monitor with a saturating error counter. One instance sits on each side of the async FIFO: read pointer into the write domain, and write pointer into the read domain.

## Interface
- ADDRSIZE, 4: pointer is ADDRSIZE+1 bits; FIFO depth 2^ADDRSIZE.
- SYNC_STAGES, 2: synchronizer flop count; legal range ≥2.
- MAX_STEP, 16: largest legal per-sample advance; legal range 1..2^(ADDRSIZE+1)-1.
- wclk  in  1  local (destination) clock; all flops on posedge.
- wrst  in  1  synchronous, active-high reset.
- async_gray  in  ADDRSIZE+1  Gray pointer from the foreign domain, asynchronous to wclk.
- err_clr  in  1  clears gray_err and err_cnt.
- sync_gray  out  ADDRSIZE+1  synchronized Gray pointer (last chain stage).
- sync_bin  out  ADDRSIZE+1  registered binary of sync_gray.
- ptr_moved  out  1  one-cycle pulse; sync_bin changed at this edge.
- ptr_delta  out  ADDRSIZE+1  advance at this edge, modulo 2^(ADDRSIZE+1); 0 when no change.
- gray_err  out  1  sticky; some delta exceeded MAX_STEP.
- err_cnt  out  8  count of violating edges, saturating at 255.

## Operation
- Chain: stage[0] <= async_gray, stage[i] <= stage[i-1], sync_gray = stage[SYNC_STAGES-1]. No logic between stages.
- bin_now = Gray-to-binary(sync_gray), combinational: b[MSB]=g[MSB], b[i]=b[i+1]^g[i].
- Each edge, unconditionally: sync_bin <= bin_now.
- d = bin_now - sync_bin, unsigned, ADDRSIZE+1 bits, wrap-around by truncation.
- Normal edge:
  - ptr_moved <= (d != 0).
  - ptr_delta <= d.
  - If d > MAX_STEP, set gray_err and increment err_cnt (saturating at 255).
- Warm-up counter wu (0..SYNC_STAGES+1):
  - Reset to 0; increments each edge until it reaches SYNC_STAGES+1, then holds.
  - While wu ≤ SYNC_STAGES at an edge, ptr_moved and ptr_delta load 0 and no error is recorded. sync_bin still loads.
  - This suppresses the false jump from the reset value to the first real sample.
- err_clr: gray_err <= 0 and err_cnt <= 0.
  - If a violation occurs on the same edge, it wins: gray_err=1, err_cnt=1.
- Reset: every flop, including the chain, wu, and all outputs, goes to 0 on the first edge with wrst=1. wrst overrides err_clr and any violation.
- Mid-operation reset: state is discarded and warm-up restarts. No ptr_moved pulse may straddle reset.

## Timing
- Reset values: sync_gray=0, sync_bin=0, ptr_moved=0, ptr_delta=0, gray_err=0, err_cnt=0.
- Counting the capture edge of a new async_gray value as edge 1:
  - sync_gray reflects it after edge SYNC_STAGES.
  - sync_bin, ptr_moved, ptr_delta and the error update after edge SYNC_STAGES+1.
- ptr_moved is high for exactly one cycle per change of sync_gray. Back-to-back changes give consecutive pulses.
- After wrst falls, the first ptr_moved is possible no earlier than edge SYNC_STAGES+2.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
Defaults ADDRSIZE=4, SYNC_STAGES=2, MAX_STEP=16.
- Reset/warm-up:
  - Stimulus: hold wrst=1 for 3 edges with async_gray=5'b10110, then release.
  - Required: all outputs 0 during reset; sync_gray=10110 after edge 2; sync_bin=27 after edge 3; ptr_moved and gray_err stay 0.
- Single step:
  - Stimulus: steady at gray 00010 (bin 3), then drive 00110 (bin 4).
  - Required: 3 edges later sync_bin=4, ptr_moved=1 for one cycle, ptr_delta=1, then ptr_delta=0.
- Wrap-around:
  - Stimulus 1: bin 31 (10000) → bin 0 (00000). Required: delta=1, pulse, no error.
  - Stimulus 2: bin 31 → bin 1 (00001). Required: delta=2.
- Overrun:
  - Stimulus: bin 0 → bin 17 (11001) in one step, then bin 17 → bin 18.
  - Required: after the first step, delta=17, gray_err=1, err_cnt=1. After the second step, delta=1, gray_err stays 1, err_cnt stays 1.
- Clear/saturation:
  - Stimulus: err_clr on the same edge as a violation. Required: gray_err=1, err_cnt=1.
  - Stimulus: 300 violating steps. Required: err_cnt=255.
  - Stimulus: err_clr alone. Required: both outputs 0.
- Mid-run reset:
  - Stimulus: pulse wrst for one edge while the pointer increments every cycle.
  - Required: all outputs 0 on the next cycle; no ptr_moved for 3 edges after release; no spurious error.

Source files
------------

// File: rtl/sync_ptr_mon.sv
// Gray pointer synchronizer with binary conversion, advance reporting
// and a sticky overrun monitor with a saturating error counter.
module sync_ptr_mon #(
  parameter int ADDRSIZE    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int MAX_STEP    = 16
) (
  input  logic                wclk,
  input  logic                wrst,
  input  logic [ADDRSIZE:0]   async_gray,
  input  logic                err_clr,
  output logic [ADDRSIZE:0]   sync_gray,
  output logic [ADDRSIZE:0]   sync_bin,
  output logic                ptr_moved,
  output logic [ADDRSIZE:0]   ptr_delta,
  output logic                gray_err,
  output logic [7:0]          err_cnt
);

  localparam int W   = ADDRSIZE + 1;
  localparam int WUW = $clog2(SYNC_STAGES + 2);
  localparam logic [WUW-1:0] WU_DONE = WUW'(SYNC_STAGES + 1);
  localparam logic [W-1:0]   STEP_MAX = W'(MAX_STEP);

  logic [W-1:0]   stage [SYNC_STAGES];
  logic [W-1:0]   bin_now;
  logic [W-1:0]   delta;
  logic [WUW-1:0] wu;
  logic           live;
  logic           viol;

  assign sync_gray = stage[SYNC_STAGES-1];

  // Plain flop chain; nothing may sit between stages.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= async_gray;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  // Gray to binary: each bit is the XOR of all gray bits at or above it.
  always_comb begin
    bin_now = '0;
    for (int i = 0; i < W; i++) begin
      bin_now[i] = ^(sync_gray >> i);
    end
  end

  // Modular advance since last edge; only trusted once warm-up is over.
  assign delta = bin_now - sync_bin;
  assign live  = (wu == WU_DONE);
  assign viol  = live && (delta > STEP_MAX);

  // Warm-up counter hides the jump from reset value to first real sample.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      wu <= '0;
    end else if (wu != WU_DONE) begin
      wu <= wu + 1'b1;
    end
  end

  // Registered binary pointer and per-edge advance report.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      sync_bin  <= '0;
      ptr_moved <= 1'b0;
      ptr_delta <= '0;
    end else begin
      sync_bin <= bin_now;
      if (live) begin
        ptr_moved <= (delta != '0);
        ptr_delta <= delta;
      end else begin
        ptr_moved <= 1'b0;
        ptr_delta <= '0;
      end
    end
  end

  // Sticky overrun flag and saturating count; a violation beats a clear.
  always_ff @(posedge wclk) begin
    if (wrst) begin
      gray_err <= 1'b0;
      err_cnt  <= '0;
    end else if (viol) begin
      gray_err <= 1'b1;
      if (err_clr) begin
        err_cnt <= 8'd1;
      end else if (err_cnt != 8'hFF) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end else if (err_clr) begin
      gray_err <= 1'b0;
      err_cnt  <= '0;
    end
  end

endmodule

// File: tb/tb_sync_ptr_mon.sv
// Randomized and directed bench for sync_ptr_mon against a
// sample-history reference model.
module tb_sync_ptr_mon;

  localparam int AW = 4;
  localparam int S  = 2;
  localparam int MS = 16;
  localparam int W  = AW + 1;

  logic         wclk = 1'b0;
  logic         wrst = 1'b1;
  logic         err_clr = 1'b0;
  logic [W-1:0] async_gray = '0;
  logic [W-1:0] sync_gray;
  logic [W-1:0] sync_bin;
  logic         ptr_moved;
  logic [W-1:0] ptr_delta;
  logic         gray_err;
  logic [7:0]   err_cnt;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q[$];
  int           m_err = 0;
  int           m_cnt = 0;
  logic [W-1:0] cur_bin = '0;

  sync_ptr_mon #(
    .ADDRSIZE(AW),
    .SYNC_STAGES(S),
    .MAX_STEP(MS)
  ) dut (
    .wclk(wclk),
    .wrst(wrst),
    .async_gray(async_gray),
    .err_clr(err_clr),
    .sync_gray(sync_gray),
    .sync_bin(sync_bin),
    .ptr_moved(ptr_moved),
    .ptr_delta(ptr_delta),
    .gray_err(gray_err),
    .err_cnt(err_cnt)
  );

  always #5 wclk = ~wclk;

  function automatic logic [W-1:0] b2g(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Independent arithmetic decode: binary value equals the running
  // prefix parity, computed from the top bit downward as an integer.
  function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
    int v;
    int p;
    v = 0;
    p = 0;
    for (int k = W - 1; k >= 0; k--) begin
      p = p ^ int'(g[k]);
      v = v * 2 + p;
    end
    return W'(v);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic tick(input logic [W-1:0] bin, input logic clr,
                      input logic rst);
    int n;
    int d;
    logic [W-1:0] e_sg;
    logic [W-1:0] e_sb;
    logic e_mv;
    int e_dl;
    async_gray = b2g(bin);
    err_clr    = clr;
    wrst       = rst;
    cur_bin    = bin;
    @(posedge wclk);
    e_sg = '0;
    e_sb = '0;
    e_mv = 1'b0;
    e_dl = 0;
    if (rst) begin
      q.delete();
      m_err = 0;
      m_cnt = 0;
    end else begin
      q.push_back(b2g(bin));
      n = q.size();
      if (n >= S) e_sg = q[n-S];
      if (n >= S + 1) e_sb = g2b(q[n-S-1]);
      if (n >= S + 2) begin
        d = (int'(g2b(q[n-S-1])) - int'(g2b(q[n-S-2])) + 64) % 32;
        e_dl = d;
        e_mv = (d != 0);
        if (d > MS) begin
          m_err = 1;
          m_cnt = clr ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
        end else if (clr) begin
          m_err = 0;
          m_cnt = 0;
        end
      end else if (clr) begin
        m_err = 0;
        m_cnt = 0;
      end
      if (q.size() > 8) void'(q.pop_front());
    end
    #1;
    chk("sync_gray", 32'(sync_gray), 32'(e_sg));
    chk("sync_bin", 32'(sync_bin), 32'(e_sb));
    chk("ptr_moved", 32'(ptr_moved), 32'(e_mv));
    chk("ptr_delta", 32'(ptr_delta), 32'(e_dl));
    chk("gray_err", 32'(gray_err), 32'(m_err));
    chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick(cur_bin, 1'b0, 1'b0);
  endtask

  task automatic walk_to(input logic [W-1:0] t);
    for (int i = 0; i < 40 && cur_bin != t; i++) begin
      tick(cur_bin + 1'b1, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // reset and warm-up
    for (int i = 0; i < 3; i++) tick(5'd27, 1'b0, 1'b1);
    chk("rst_gray", 32'(sync_gray), 32'd0);
    tick(5'd27, 1'b0, 1'b0);
    tick(5'd27, 1'b0, 1'b0);
    chk("wu_gray", 32'(sync_gray), 32'b10110);
    tick(5'd27, 1'b0, 1'b0);
    chk("wu_bin", 32'(sync_bin), 32'd27);
    chk("wu_moved", 32'(ptr_moved), 32'd0);
    hold(3);
    chk("wu_err", 32'(gray_err), 32'd0);

    // single step 3 -> 4
    tick(5'd3, 1'b0, 1'b0);
    hold(4);
    tick(5'd4, 1'b0, 1'b0);
    hold(2);
    chk("step_bin", 32'(sync_bin), 32'd4);
    chk("step_moved", 32'(ptr_moved), 32'd1);
    chk("step_delta", 32'(ptr_delta), 32'd1);
    hold(1);
    chk("step_moved2", 32'(ptr_moved), 32'd0);
    chk("step_delta2", 32'(ptr_delta), 32'd0);

    // wrap-around
    walk_to(5'd31);
    hold(4);
    tick(5'd0, 1'b0, 1'b0);
    hold(2);
    chk("wrap1_delta", 32'(ptr_delta), 32'd1);
    chk("wrap1_err", 32'(gray_err), 32'd0);
    walk_to(5'd31);
    hold(4);
    tick(5'd1, 1'b0, 1'b0);
    hold(2);
    chk("wrap2_delta", 32'(ptr_delta), 32'd2);

    // overrun then normal step
    walk_to(5'd0);
    hold(4);
    tick(5'd17, 1'b0, 1'b0);
    hold(2);
    chk("ovr_delta", 32'(ptr_delta), 32'd17);
    chk("ovr_err", 32'(gray_err), 32'd1);
    chk("ovr_cnt", 32'(err_cnt), 32'd1);
    tick(5'd18, 1'b0, 1'b0);
    hold(2);
    chk("ovr2_delta", 32'(ptr_delta), 32'd1);
    chk("ovr2_err", 32'(gray_err), 32'd1);
    chk("ovr2_cnt", 32'(err_cnt), 32'd1);

    // clear coinciding with a violation (18 -> 3 is +17)
    hold(3);
    tick(5'd18, 1'b0, 1'b0);
    tick(5'd3, 1'b0, 1'b0);
    tick(5'd3, 1'b0, 1'b0);
    tick(5'd3, 1'b1, 1'b0);
    chk("clrv_err", 32'(gray_err), 32'd1);
    chk("clrv_cnt", 32'(err_cnt), 32'd1);

    // saturation
    for (int i = 0; i < 300; i++) tick(cur_bin + 5'd20, 1'b0, 1'b0);
    hold(4);
    chk("sat_cnt", 32'(err_cnt), 32'd255);

    // plain clear
    tick(cur_bin, 1'b1, 1'b0);
    chk("clr_err", 32'(gray_err), 32'd0);
    chk("clr_cnt", 32'(err_cnt), 32'd0);

    // mid-run reset while incrementing
    for (int i = 0; i < 8; i++) tick(cur_bin + 1'b1, 1'b0, 1'b0);
    tick(cur_bin + 1'b1, 1'b0, 1'b1);
    chk("mrst_bin", 32'(sync_bin), 32'd0);
    chk("mrst_moved", 32'(ptr_moved), 32'd0);
    chk("mrst_delta", 32'(ptr_delta), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick(cur_bin + 1'b1, 1'b0, 1'b0);
      chk("mrst_wu_moved", 32'(ptr_moved), 32'd0);
    end
    for (int i = 0; i < 4; i++) tick(cur_bin + 1'b1, 1'b0, 1'b0);
    chk("mrst_moved_on", 32'(ptr_moved), 32'd1);
    chk("mrst_err", 32'(gray_err), 32'd0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      logic [W-1:0] nb;
      r = $urandom_range(0, 99);
      if (r < 60) nb = cur_bin + W'($urandom_range(0, 2));
      else if (r < 90) nb = cur_bin + W'($urandom_range(0, 16));
      else nb = W'($urandom_range(0, 31));
      tick(nb, ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 99) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
